// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
  localparam logic [31:0] INSTR_NOP        = 32'h00000000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One buffered fetch: PC, instruction word and address-error flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  // RUN fetches normally; HALT parks the stage after a misaligned redirect.
  typedef enum logic {
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a flush discards every entry at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests
// under a credit limit, buffers responses and presents them to decode.
// Optional feature macro IF_EXC_ADDR_EN: misaligned redirects raise an
// address-error entry (id_adel) instead of silently clearing the low bits.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
`ifdef IF_EXC_ADDR_EN
  output logic        id_adel,
`endif
  output logic [31:0] id_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_base;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          run_ok;
  logic          accept;
  logic          resp_fire;
  logic          resp_keep;
  logic          exc_push;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  exc_entry;
  fetch_entry_t  push_data;

  assign redirect_base = {redirect_pc[31:2], 2'b00};
  assign in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok     = (in_use < (CW+1)'(DEPTH));

  assign imem_req_valid = !rst && !redirect_valid && credit_ok && run_ok;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to pre-reset requests and are ignored.
  assign resp_fire = imem_resp_valid && (outstanding != '0);
  assign resp_keep = resp_fire && (drop == '0) && !redirect_valid;
  assign out_next  = outstanding + CW'(accept) - CW'(resp_fire);

  // Fetch PC, expected response PC and the in-flight / stale counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        drop     <= out_next;
      end else begin
        if (accept)    fetch_pc <= fetch_pc + PC_STEP;
        if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
        if (resp_fire && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Select what enters the FIFO: a fetched word or the address-error marker.
  always_comb begin
    push_data = '{pc: resp_pc, instr: imem_resp_data, adel: 1'b0};
    if (exc_push) push_data = exc_entry;
  end

  assign fifo_push = resp_keep || exc_push;
  assign fifo_pop  = id_valid && id_ready;

  if_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign id_valid = !fifo_empty;
  assign id_pc    = id_valid ? fifo_head.pc    : '0;
  assign id_instr = id_valid ? fifo_head.instr : '0;

  // The credit limit makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

`ifdef IF_EXC_ADDR_EN
  fetch_state_e state;
  fetch_state_e state_next;
  logic         exc_pending;
  logic [31:0]  exc_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Every redirect chooses RUN or HALT from the target's alignment.
  always_comb begin
    state_next = state;
    if (redirect_valid) state_next = (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
  end

  // HALT stops requests and emits the error entry once stale responses drain.
  always_comb begin
    run_ok   = (state == RUN);
    exc_push = (state == HALT) && exc_pending && (drop == '0) && !redirect_valid;
  end

  // Remember the faulting target until its error entry has been queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_pending <= 1'b0;
      exc_pc      <= '0;
    end else if (redirect_valid) begin
      exc_pending <= (redirect_pc[1:0] != 2'b00);
      exc_pc      <= redirect_pc;
    end else if (exc_push) begin
      exc_pending <= 1'b0;
    end
  end

  assign exc_entry = '{pc: exc_pc, instr: INSTR_NOP, adel: 1'b1};
  assign id_adel   = id_valid && fifo_head.adel;
`else
  logic [2:0] unused_bits;

  assign run_ok      = 1'b1;
  assign exc_push    = 1'b0;
  assign exc_entry   = '0;
  assign unused_bits = {redirect_pc[1:0], fifo_head.adel};
`endif

endmodule
